// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: CP0 exception codes,
// MEM flag bit positions, controller states and stall vector values.
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_NONE     = 32'h0;
  localparam logic [31:0] EXC_INT      = 32'h1;
  localparam logic [31:0] EXC_SYSCALL  = 32'h8;
  localparam logic [31:0] EXC_INVALID  = 32'ha;
  localparam logic [31:0] EXC_TRAP     = 32'hd;
  localparam logic [31:0] EXC_OVERFLOW = 32'hc;
  localparam logic [31:0] EXC_ERET     = 32'he;

  localparam int FLAG_SYSCALL  = 0;
  localparam int FLAG_INVALID  = 1;
  localparam int FLAG_TRAP     = 2;
  localparam int FLAG_OVERFLOW = 3;
  localparam int FLAG_ERET     = 4;

  typedef enum logic {
    ST_RUN,
    ST_DRAIN
  } state_t;

  // Stall vector bit order is {wb, mem, ex, id, if, pc}.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

endpackage

// File: rtl/exc_ctrl.sv
// Exception/flush controller: picks the MEM-stage event, redirects the PC,
// holds flush for FLUSH_CYCLES and merges stall requests. EXC_CTRL_INT_EN enables interrupts.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_exc_flags_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [5:0]  stall_o,
  output logic [15:0] exc_count_o
);

  localparam logic [1:0] DRAIN_LEN = 2'(FLUSH_CYCLES - 1);

  function automatic logic [31:0] sel_exc(input logic int_pend, input logic [4:0] flags);
    if (int_pend)                    return EXC_INT;
    else if (flags[FLAG_SYSCALL])    return EXC_SYSCALL;
    else if (flags[FLAG_INVALID])    return EXC_INVALID;
    else if (flags[FLAG_TRAP])       return EXC_TRAP;
    else if (flags[FLAG_OVERFLOW])   return EXC_OVERFLOW;
    else if (flags[FLAG_ERET])       return EXC_ERET;
    else                             return EXC_NONE;
  endfunction

  state_t      r_state;
  logic        r_int_pend;
  logic [1:0]  r_drain_cnt;
  logic [31:0] r_new_pc;
  logic [15:0] r_exc_count;

  logic        w_int_pend_next;
  logic [31:0] w_exc_code;
  logic        w_accept;
  logic        w_draining;
  logic [31:0] w_accept_pc;
  logic        w_unused;

`ifdef EXC_CTRL_INT_EN
  assign w_int_pend_next = (|(cp0_cause_i[15:8] & cp0_status_i[15:8]))
                           & cp0_status_i[0] & ~cp0_status_i[1];
`else
  assign w_int_pend_next = 1'b0;
`endif
  // Only a few CP0 bits matter here; fold the rest away.
  assign w_unused = ^{cp0_status_i, cp0_cause_i};

  assign w_exc_code  = sel_exc(r_int_pend, mem_exc_flags_i);
  assign w_draining  = (r_state == ST_DRAIN);
  assign w_accept    = (r_state == ST_RUN) && mem_valid_i && (w_exc_code != EXC_NONE);
  assign w_accept_pc = (w_exc_code == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;

  always_comb begin
    excepttype_o        = EXC_NONE;
    current_inst_addr_o = 32'h0;
    is_in_delayslot_o   = 1'b0;
    flush_o             = 1'b0;
    new_pc_o            = 32'h0;
    stall_o             = STALL_NONE;
    if (w_accept) begin
      excepttype_o        = w_exc_code;
      current_inst_addr_o = mem_pc_i;
      is_in_delayslot_o   = mem_in_delayslot_i;
      flush_o             = 1'b1;
      new_pc_o            = w_accept_pc;
    end else if (w_draining) begin
      flush_o  = 1'b1;
      new_pc_o = r_new_pc;
    end else if (stallreq_ex_i) begin
      stall_o = STALL_EX;
    end else if (stallreq_id_i) begin
      stall_o = STALL_ID;
    end
  end

  assign exc_count_o = r_exc_count;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= ST_RUN;
      r_int_pend  <= 1'b0;
      r_drain_cnt <= 2'd0;
      r_new_pc    <= 32'h0;
      r_exc_count <= 16'h0;
    end else begin
      r_int_pend <= w_int_pend_next;
      if (w_accept) begin
        r_exc_count <= r_exc_count + 16'd1;
        r_new_pc    <= w_accept_pc;
        if (DRAIN_LEN != 2'd0) begin
          r_state     <= ST_DRAIN;
          r_drain_cnt <= DRAIN_LEN;
        end
      end else if (w_draining) begin
        // Events arriving while draining are dropped, not queued.
        if (r_drain_cnt <= 2'd1) begin
          r_state     <= ST_RUN;
          r_drain_cnt <= 2'd0;
        end else begin
          r_drain_cnt <= r_drain_cnt - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomized bench for exc_ctrl: two instances (flush length 1 and 3) share
// stimulus and are checked against a cycle-level reference model.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallreq_id, stallreq_ex, mem_valid, mem_ds;
  logic [4:0]  flags;
  logic [31:0] mem_pc, status, cause, epc;

  logic [31:0] o_type [2];
  logic [31:0] o_addr [2];
  logic        o_ds   [2];
  logic        o_flush[2];
  logic [31:0] o_npc  [2];
  logic [5:0]  o_stall[2];
  logic [15:0] o_cnt  [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  exc_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .stallreq_id_i(stallreq_id), .stallreq_ex_i(stallreq_ex),
    .mem_valid_i(mem_valid), .mem_exc_flags_i(flags), .mem_pc_i(mem_pc),
    .mem_in_delayslot_i(mem_ds), .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
    .excepttype_o(o_type[0]), .current_inst_addr_o(o_addr[0]), .is_in_delayslot_o(o_ds[0]),
    .flush_o(o_flush[0]), .new_pc_o(o_npc[0]), .stall_o(o_stall[0]), .exc_count_o(o_cnt[0]));

  exc_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .stallreq_id_i(stallreq_id), .stallreq_ex_i(stallreq_ex),
    .mem_valid_i(mem_valid), .mem_exc_flags_i(flags), .mem_pc_i(mem_pc),
    .mem_in_delayslot_i(mem_ds), .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
    .excepttype_o(o_type[1]), .current_inst_addr_o(o_addr[1]), .is_in_delayslot_o(o_ds[1]),
    .flush_o(o_flush[1]), .new_pc_o(o_npc[1]), .stall_o(o_stall[1]), .exc_count_o(o_cnt[1]));

  // Reference model state, one slot per instance.
  int          m_drain [2] = '{0, 0};
  logic [31:0] m_pc    [2] = '{0, 0};
  int          m_count [2] = '{0, 0};
  bit          m_int       = 1'b0;
  bit          e_acc   [2];
  logic [31:0] e_npc   [2];
  int          flush_len [2] = '{1, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic quiet();
    stallreq_id = 0; stallreq_ex = 0; mem_valid = 0; mem_ds = 0;
    flags = 0; mem_pc = 0; status = 0; cause = 0; epc = 0;
  endtask

  // Evaluate one cycle: expected outputs at negedge, model advance at posedge.
  task automatic step(input bit chk_en, input string tag);
    logic [31:0] e_type;
    logic [31:0] e_addr;
    bit          e_ds, e_flush;
    logic [5:0]  e_stall;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      e_type = 0; e_addr = 0; e_ds = 0; e_flush = 0; e_stall = 0;
      e_acc[k] = 0; e_npc[k] = 0;
      if (m_drain[k] > 0) begin
        e_flush = 1; e_npc[k] = m_pc[k];
      end else if (mem_valid && (m_int || flags != 0)) begin
        if (m_int)         e_type = 32'h1;
        else if (flags[0]) e_type = 32'h8;
        else if (flags[1]) e_type = 32'ha;
        else if (flags[2]) e_type = 32'hd;
        else if (flags[3]) e_type = 32'hc;
        else               e_type = 32'he;
        e_acc[k] = 1; e_flush = 1;
        e_addr = mem_pc; e_ds = mem_ds;
        e_npc[k] = (e_type == 32'he) ? epc : 32'h20;
      end else if (stallreq_ex) begin
        e_stall = 6'b001111;
      end else if (stallreq_id) begin
        e_stall = 6'b000111;
      end
      if (chk_en) begin
        chk($sformatf("%s.type%0d", tag, k), o_type[k], e_type);
        chk($sformatf("%s.flush%0d", tag, k), 32'(o_flush[k]), 32'(e_flush));
        chk($sformatf("%s.npc%0d", tag, k), o_npc[k], e_npc[k]);
        chk($sformatf("%s.stall%0d", tag, k), 32'(o_stall[k]), 32'(e_stall));
        chk($sformatf("%s.cnt%0d", tag, k), 32'(o_cnt[k]), 32'(m_count[k] % 65536));
        if (m_drain[k] == 0) begin
          chk($sformatf("%s.addr%0d", tag, k), o_addr[k], e_addr);
          chk($sformatf("%s.ds%0d", tag, k), 32'(o_ds[k]), 32'(e_ds));
        end
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        m_drain[k] = 0; m_pc[k] = 0; m_count[k] = 0;
      end else if (e_acc[k]) begin
        m_count[k] = (m_count[k] + 1) % 65536;
        m_pc[k] = e_npc[k];
        m_drain[k] = flush_len[k] - 1;
      end else if (m_drain[k] > 0) begin
        m_drain[k]--;
      end
    end
`ifdef EXC_CTRL_INT_EN
    m_int = !rst_n && ((cause[15:8] & status[15:8]) != 0) && status[0] && !status[1];
`else
    m_int = 0;
`endif
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    quiet();
    for (int i = 0; i < n; i++) step(1, tag);
  endtask

  initial begin
    quiet();
    rst_n = 1;
    step(0, "rst"); step(0, "rst");
    rst_n = 0;
    idle(1, "reset_state");

    // syscall at pc 0x100
    mem_valid = 1; flags = 5'b00001; mem_pc = 32'h100;
    step(1, "syscall");
    idle(3, "post_sys");

    // eret returns to EPC
    mem_valid = 1; flags = 5'b10000; epc = 32'h204; mem_pc = 32'h300; mem_ds = 1;
    step(1, "eret");
    idle(3, "post_eret");

    // interrupt enabled, then masked by EXL
    status = 32'h0000ff01; cause = 32'h400; mem_valid = 1; mem_pc = 32'h40;
    step(1, "int_arm");
    step(1, "int_take");
    idle(3, "post_int");
    status = 32'h0000ff03; cause = 32'h400; mem_valid = 1;
    step(1, "int_exl_arm");
    step(1, "int_exl");
    idle(3, "post_exl");

    // invalid beats overflow and overrides an EX stall
    mem_valid = 1; flags = 5'b01010; stallreq_ex = 1; mem_pc = 32'h80;
    step(1, "prio_stall");
    idle(3, "post_prio");
    stallreq_ex = 1; stallreq_id = 1; step(1, "stall_ex");
    stallreq_ex = 0; step(1, "stall_id");
    mem_valid = 0; flags = 5'b00100; step(1, "no_valid");

    // trap, then syscall while the 3-cycle instance drains
    quiet(); mem_valid = 1; flags = 5'b00100; mem_pc = 32'h500;
    step(1, "trap");
    flags = 5'b00001; mem_pc = 32'h504;
    step(1, "sys_in_drain");
    idle(3, "post_drain");

    // reset in the middle of a drain
    mem_valid = 1; flags = 5'b01000; step(1, "ovf");
    quiet(); rst_n = 1; step(1, "rst_mid");
    rst_n = 0; idle(2, "after_rst");
    chk("rst_flush3", 32'(o_flush[1]), 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 299) == 0);
      stallreq_id = $urandom_range(0, 1) == 1;
      stallreq_ex = $urandom_range(0, 3) == 0;
      mem_valid   = $urandom_range(0, 1) == 1;
      flags       = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h0;
      mem_pc      = $urandom & 32'hffff_fffc;
      mem_ds      = $urandom_range(0, 1) == 1;
      status      = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
      cause       = ($urandom_range(0, 7) == 0) ? {16'h0, 8'($urandom), 8'h0} : 32'h0;
      epc         = $urandom;
      step(1, "rand");
    end

    // counter wrap on the single-cycle instance
    quiet(); rst_n = 1; step(0, "wrap_rst");
    rst_n = 0;
    mem_valid = 1; flags = 5'b00001;
    for (int i = 0; i < 65535; i++) step(0, "wrap");
    chk("wrap_ffff", 32'(o_cnt[0]), 32'hffff);
    step(0, "wrap");
    quiet(); step(1, "wrapped");
    chk("wrap_zero", 32'(o_cnt[0]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
